// File: rtl/core_target_cmd_pkg.sv
// Shared types and constants for the target-to-host command mailbox arbiter:
// FSM state encoding, mailbox magic words and the target command code set.
package core_target_cmd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_ARM   = 3'd2,
    ST_WAIT  = 3'd3,
    ST_DONE  = 3'd4
  } arb_state_e;

  localparam logic [15:0] CMD_MAGIC   = 16'h636D;
  localparam logic [15:0] ACK_MAGIC   = 16'h6F6B;
  localparam logic [15:0] RES_TIMEOUT = 16'hFFFE;

  localparam logic [15:0] TCMD_READYTORUN = 16'h0140;
  localparam logic [15:0] TCMD_DISPMSG    = 16'h0180;
  localparam logic [15:0] TCMD_SLOTREAD   = 16'h0190;
  localparam logic [15:0] TCMD_SLOTRELOAD = 16'h0192;
  localparam logic [15:0] TCMD_SLOTWRITE  = 16'h0194;
  localparam logic [15:0] TCMD_SLOTFLUSH  = 16'h0196;

  function automatic logic [31:0] mk_cmd_word(input logic [15:0] cmd);
    return {CMD_MAGIC, cmd};
  endfunction

endpackage

// File: rtl/core_target_cmd_arb_if.sv
// Requester and mailbox signals of core_target_cmd_arb; the slave modport is
// the arbiter side, the master modport is the requester/host side.
interface core_target_cmd_arb_if #(
  parameter int NREQ = 4
) ();

  logic [NREQ-1:0]    req;
  logic [16*NREQ-1:0] req_cmd;
  logic [32*NREQ-1:0] req_param;
  logic [NREQ-1:0]    gnt;
  logic [NREQ-1:0]    done;
  logic [15:0]        result;
  logic               busy;
  logic               mb_wr;
  logic [31:0]        mb_cmd;
  logic [31:0]        mb_param;
  logic [31:0]        mb_status;

  modport slave (
    input  req, req_cmd, req_param, mb_status,
    output gnt, done, result, busy, mb_wr, mb_cmd, mb_param
  );

  modport master (
    output req, req_cmd, req_param, mb_status,
    input  gnt, done, result, busy, mb_wr, mb_cmd, mb_param
  );

endinterface

// File: rtl/core_target_cmd_arb_rr.sv
// Combinational round-robin pick: the search starts one past the last winner
// and the first requesting index wins.
module core_rr_arb #(
  parameter int NREQ = 4,
  parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   last_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IW-1:0]   idx_o,
  output logic            vld_o
);

  logic [IW-1:0] cand_s;

  // rotating first-set search over all requesters
  always_comb begin
    gnt_o  = '0;
    idx_o  = '0;
    vld_o  = 1'b0;
    cand_s = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand_s = IW'((int'(last_i) + k) % NREQ);
      if (!vld_o && req_i[cand_s]) begin
        vld_o         = 1'b1;
        gnt_o[cand_s] = 1'b1;
        idx_o         = cand_s;
      end else begin
        vld_o = vld_o;
      end
    end
  end

endmodule

// File: rtl/core_target_cmd_arb.sv
// Round-robin command sequencer for the target_0/target_20 mailbox words.
// Optional watchdog enabled by defining CORE_TARGET_CMD_TIMEOUT_EN.
module core_target_cmd_arb
  import core_target_cmd_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int TIMEOUT_W = 24
) (
  input logic                 clk,
  input logic                 rst,
  core_target_cmd_arb_if.slave bus
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  arb_state_e        state_q;
  logic [NREQ-1:0]   gnt_q;
  logic [NREQ-1:0]   done_q;
  logic              busy_q;
  logic              mb_wr_q;
  logic [15:0]       result_q;
  logic [31:0]       mb_cmd_q;
  logic [31:0]       mb_param_q;
  logic [IW-1:0]     idx_q;
  logic [IW-1:0]     last_q;

  logic [NREQ-1:0]   pick_gnt_s;
  logic [IW-1:0]     pick_idx_s;
  logic              pick_vld_s;
  logic [15:0]       sel_cmd_s;
  logic [31:0]       sel_param_s;
  logic              cmd_seen_s;
  logic              ack_seen_s;
  logic              tmo_hit_s;

  core_rr_arb #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_rr (
    .req_i  (bus.req),
    .last_i (last_q),
    .gnt_o  (pick_gnt_s),
    .idx_o  (pick_idx_s),
    .vld_o  (pick_vld_s)
  );

  // operand mux for the winning requester's command and parameter
  always_comb begin
    sel_cmd_s   = 16'h0000;
    sel_param_s = 32'h0000_0000;
    for (int i = 0; i < NREQ; i++) begin
      if (pick_gnt_s[i]) begin
        sel_cmd_s   = bus.req_cmd[16*i +: 16];
        sel_param_s = bus.req_param[32*i +: 32];
      end else begin
        sel_cmd_s   = sel_cmd_s;
      end
    end
  end

  // ARM insists on our own magic first so a stale acknowledge is never taken
  assign cmd_seen_s = (bus.mb_status[31:16] == CMD_MAGIC);
  assign ack_seen_s = (bus.mb_status[31:16] == ACK_MAGIC);

`ifdef CORE_TARGET_CMD_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] tmo_q;

  // watchdog: cleared at issue, counts every ARM/WAIT cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_q <= '0;
    end else if (state_q == ST_ISSUE) begin
      tmo_q <= '0;
    end else if ((state_q == ST_ARM) || (state_q == ST_WAIT)) begin
      tmo_q <= tmo_q + TIMEOUT_W'(1);
    end else begin
      tmo_q <= tmo_q;
    end
  end

  assign tmo_hit_s = &tmo_q;
`else
  localparam int unused_timeout_w = TIMEOUT_W;
  assign tmo_hit_s = 1'b0;
`endif

  // command sequencer; every output is a register set on state entry
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      gnt_q      <= '0;
      done_q     <= '0;
      busy_q     <= 1'b0;
      mb_wr_q    <= 1'b0;
      result_q   <= 16'h0000;
      mb_cmd_q   <= 32'h0000_0000;
      mb_param_q <= 32'h0000_0000;
      idx_q      <= '0;
      last_q     <= IW'(NREQ - 1);
    end else begin
      mb_wr_q <= 1'b0;
      done_q  <= '0;
      case (state_q)
        ST_IDLE: begin
          if (pick_vld_s) begin
            idx_q      <= pick_idx_s;
            gnt_q      <= pick_gnt_s;
            mb_cmd_q   <= mk_cmd_word(sel_cmd_s);
            mb_param_q <= sel_param_s;
            mb_wr_q    <= 1'b1;
            busy_q     <= 1'b1;
            state_q    <= ST_ISSUE;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_ISSUE: begin
          state_q <= ST_ARM;
        end
        ST_ARM: begin
          if (cmd_seen_s) begin
            state_q <= ST_WAIT;
          end else if (tmo_hit_s) begin
            result_q <= RES_TIMEOUT;
            done_q   <= gnt_q;
            gnt_q    <= '0;
            last_q   <= idx_q;
            state_q  <= ST_DONE;
          end else begin
            state_q <= ST_ARM;
          end
        end
        ST_WAIT: begin
          if (ack_seen_s) begin
            result_q <= bus.mb_status[15:0];
            done_q   <= gnt_q;
            gnt_q    <= '0;
            last_q   <= idx_q;
            state_q  <= ST_DONE;
          end else if (tmo_hit_s) begin
            result_q <= RES_TIMEOUT;
            done_q   <= gnt_q;
            gnt_q    <= '0;
            last_q   <= idx_q;
            state_q  <= ST_DONE;
          end else begin
            state_q <= ST_WAIT;
          end
        end
        ST_DONE: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          gnt_q   <= '0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.gnt      = gnt_q;
  assign bus.done     = done_q;
  assign bus.result   = result_q;
  assign bus.busy     = busy_q;
  assign bus.mb_wr    = mb_wr_q;
  assign bus.mb_cmd   = mb_cmd_q;
  assign bus.mb_param = mb_param_q;

endmodule

// File: tb/tb_core_target_cmd_arb.sv
// Directed bench for core_target_cmd_arb with a hand-driven host mailbox.
// Define CORE_TARGET_CMD_TIMEOUT_EN to exercise the watchdog path.
module tb_core_target_cmd_arb;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  core_target_cmd_arb_if #(.NREQ(4)) bus_if ();

  core_target_cmd_arb #(
    .NREQ      (4),
    .TIMEOUT_W (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // grant edge, mailbox write lands, host acks three cycles later
  task automatic host_txn(input string tag, input logic [3:0] exp_gnt,
                          input logic [31:0] exp_cmd, input logic [31:0] exp_param,
                          input logic [15:0] res);
    step();
    chk({tag, "_gnt"}, 64'(bus_if.gnt), 64'(exp_gnt));
    chk({tag, "_wr"}, 64'(bus_if.mb_wr), 64'd1);
    chk({tag, "_cmd"}, 64'(bus_if.mb_cmd), 64'(exp_cmd));
    chk({tag, "_param"}, 64'(bus_if.mb_param), 64'(exp_param));
    bus_if.mb_status = exp_cmd;
    for (int c = 0; c < 3; c++) begin
      step();
      chk({tag, "_hold"}, {60'd0, bus_if.gnt}, {60'd0, exp_gnt});
      chk({tag, "_nodone"}, 64'(bus_if.done), 64'd0);
    end
    bus_if.mb_status = {16'h6F6B, res};
    step();
    chk({tag, "_done"}, 64'(bus_if.done), 64'(exp_gnt));
    chk({tag, "_result"}, 64'(bus_if.result), 64'(res));
    chk({tag, "_gntclr"}, 64'(bus_if.gnt), 64'd0);
  endtask

  initial begin
    int  order [5];
    bit  seen;
    n_tests = 0;
    n_fail  = 0;
    order   = '{0, 1, 2, 3, 0};
    rst              = 1'b1;
    bus_if.req       = 4'b0000;
    bus_if.req_cmd   = 64'd0;
    bus_if.req_param = 128'd0;
    bus_if.mb_status = 32'd0;
    step();
    step();
    chk("rst_gnt", 64'(bus_if.gnt), 64'd0);
    chk("rst_done", 64'(bus_if.done), 64'd0);
    chk("rst_busy", 64'(bus_if.busy), 64'd0);
    chk("rst_wr", 64'(bus_if.mb_wr), 64'd0);
    chk("rst_res", 64'(bus_if.result), 64'd0);
    chk("rst_cmd", 64'(bus_if.mb_cmd), 64'd0);
    chk("rst_param", 64'(bus_if.mb_param), 64'd0);
    rst = 1'b0;
    step();

    // single request from requester 0
    bus_if.req_cmd[15:0]   = 16'h0140;
    bus_if.req_param[31:0] = 32'h0000_0000;
    bus_if.req             = 4'b0001;
    host_txn("single", 4'b0001, 32'h636D0140, 32'h0000_0000, 16'h0000);
    bus_if.req = 4'b0000;
    step();
    chk("single_idle_busy", 64'(bus_if.busy), 64'd0);
    chk("single_idle_done", 64'(bus_if.done), 64'd0);

    // rotation with every requester asserted; restart from reset
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus_if.req_cmd[16*i +: 16]   = 16'h0180 + 16'(i);
      bus_if.req_param[32*i +: 32] = 32'hA000_0000 + 32'(i);
    end
    bus_if.req = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      host_txn($sformatf("rot%0d", n), 4'(1 << order[n]),
               {16'h636D, 16'h0180 + 16'(order[n])},
               32'hA000_0000 + 32'(order[n]), 16'(16'h0010 + n));
      if (n == 4) bus_if.req = 4'b0000;
      step();
      chk($sformatf("rot%0d_idle", n), 64'(bus_if.busy), 64'd0);
    end

    // stale acknowledge left in the mailbox from the previous command
    bus_if.mb_status         = 32'h6F6B0002;
    bus_if.req_cmd[47:32]    = 16'h0190;
    bus_if.req               = 4'b0100;
    step();
    chk("stale_gnt", 64'(bus_if.gnt), 64'b0100);
    for (int c = 0; c < 3; c++) begin
      step();
      chk("stale_nodone_old", 64'(bus_if.done), 64'd0);
    end
    bus_if.mb_status = 32'h636D0190;
    step();
    chk("stale_nodone_arm", 64'(bus_if.done), 64'd0);
    step();
    chk("stale_nodone_wait", 64'(bus_if.done), 64'd0);
    bus_if.mb_status = 32'h6F6B0005;
    step();
    chk("stale_done", 64'(bus_if.done), 64'b0100);
    chk("stale_result", 64'(bus_if.result), 64'h5);
    bus_if.req = 4'b0000;
    step();

    // requester 1 drops its request right after the grant
    bus_if.req_cmd[31:16] = 16'h0194;
    bus_if.req            = 4'b0010;
    step();
    chk("drop_gnt", 64'(bus_if.gnt), 64'b0010);
    chk("drop_cmd", 64'(bus_if.mb_cmd), 64'h636D0194);
    bus_if.req       = 4'b0000;
    bus_if.mb_status = 32'h636D0194;
    step();
    step();
    bus_if.mb_status = 32'h6F6B0007;
    step();
    chk("drop_done", 64'(bus_if.done), 64'b0010);
    chk("drop_result", 64'(bus_if.result), 64'h7);
    step();
    step();
    chk("drop_nogrant", 64'(bus_if.gnt), 64'd0);
    chk("drop_notbusy", 64'(bus_if.busy), 64'd0);

    // reset while waiting for the host, then requester 3 wins again
    bus_if.req_cmd[63:48]    = 16'h0196;
    bus_if.req_param[127:96] = 32'h1234_5678;
    bus_if.req               = 4'b1000;
    step();
    chk("rw_gnt", 64'(bus_if.gnt), 64'b1000);
    bus_if.mb_status = 32'h636D0196;
    step();
    step();
    step();
    chk("rw_busy_wait", 64'(bus_if.busy), 64'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rw_gnt0", 64'(bus_if.gnt), 64'd0);
    chk("rw_done0", 64'(bus_if.done), 64'd0);
    chk("rw_busy0", 64'(bus_if.busy), 64'd0);
    chk("rw_wr0", 64'(bus_if.mb_wr), 64'd0);
    chk("rw_res0", 64'(bus_if.result), 64'd0);
    chk("rw_cmd0", 64'(bus_if.mb_cmd), 64'd0);
    chk("rw_param0", 64'(bus_if.mb_param), 64'd0);
    step();
    chk("rw_regnt", 64'(bus_if.gnt), 64'b1000);
    chk("rw_recmd", 64'(bus_if.mb_cmd), 64'h636D0196);
    chk("rw_reparam", 64'(bus_if.mb_param), 64'h1234_5678);
    step();
    step();
    bus_if.mb_status = 32'h6F6B0009;
    step();
    chk("rw_done", 64'(bus_if.done), 64'b1000);
    chk("rw_result", 64'(bus_if.result), 64'h9);
    bus_if.req = 4'b0000;
    step();

    // host never answers
    bus_if.mb_status = 32'h0000_0000;
    bus_if.req       = 4'b0001;
    step();
    chk("tmo_gnt", 64'(bus_if.gnt), 64'b0001);
    seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      step();
      if (bus_if.done != 4'b0000) seen = 1'b1;
    end
`ifdef CORE_TARGET_CMD_TIMEOUT_EN
    chk("tmo_seen", 64'(seen), 64'd1);
    chk("tmo_done", 64'(bus_if.done), 64'b0001);
    chk("tmo_result", 64'(bus_if.result), 64'hFFFE);
`else
    chk("tmo_seen", 64'(seen), 64'd0);
    chk("tmo_busy", 64'(bus_if.busy), 64'd1);
`endif
    bus_if.req = 4'b0000;
    rst        = 1'b1;
    step();
    rst = 1'b0;
    step();
    chk("end_busy", 64'(bus_if.busy), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
